// File: rtl/icache_pkg.sv
// icache_pkg: cache geometry, derived widths and refill FSM state type
package icache_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int INDEX_BITS = 4;
   localparam int WORDS_PER_LINE = 4;
   localparam logic [15:0] UC_HI = 16'h1c09;
   localparam int WO = $clog2(WORDS_PER_LINE);
   localparam int TAG_W = ADDR_W - INDEX_BITS - WO - 2;
   localparam int LINES = 2 ** INDEX_BITS;
   typedef enum logic [1:0] {IDLE, REFILL, UNCACHED} state_t;
endpackage

// File: rtl/icache_line_refill_if.sv
// icache_line_refill_if: fetch-side and memory-side signals of the instruction cache
interface icache_line_refill_if;
   import icache_pkg::*;
   logic cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_inst;
   logic cpu_valid;
   logic cpu_stall;
   logic flush;
   logic mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic mem_rvalid;
   modport master (
      output cpu_req, cpu_addr, flush, mem_rdata, mem_rvalid,
      input  cpu_inst, cpu_valid, cpu_stall, mem_req, mem_addr
   );
   modport slave (
      input  cpu_req, cpu_addr, flush, mem_rdata, mem_rvalid,
      output cpu_inst, cpu_valid, cpu_stall, mem_req, mem_addr
   );
endinterface

// File: rtl/icache_line_store.sv
// icache_line_store: tag/valid/data arrays with async read and one-word-per-cycle write
module icache_line_store import icache_pkg::*; (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [INDEX_BITS-1:0] rd_idx,
   input  logic [WO-1:0]         rd_off,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  logic [WO-1:0]         wr_off,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  set_en,
   input  logic [TAG_W-1:0]      set_tag
);
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [DATA_W-1:0] data [LINES*WORDS_PER_LINE];
   assign rd_valid = valid[rd_idx];
   assign rd_tag = tags[rd_idx];
   assign rd_data = data[{rd_idx, rd_off}];
   always_ff @(posedge clk) begin
      if (wr_en) data[{wr_idx, wr_off}] <= wr_data;
      if (set_en) tags[wr_idx] <= set_tag;
   end
   // valid bits are flops so reset and flush wipe every line in one edge
   always_ff @(posedge clk)
      if (!reset || clear) valid <= '0;
      else if (set_en) valid[wr_idx] <= 1'b1;
endmodule

// File: rtl/icache_line_refill.sv
// icache_line_refill: direct-mapped I-cache with blocking line refill, uncached bypass and flush
module icache_line_refill import icache_pkg::*; (
   input logic clk,
   input logic reset,
   icache_line_refill_if.slave bus
);
   localparam int IB = WO + 2;
   state_t state;
   logic [WO-1:0] ctr, nxt, off;
   logic [INDEX_BITS-1:0] idx, base_idx;
   logic [TAG_W-1:0] tag, base_tag, rd_tag;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] addr_q;
   logic flush_pend, req_q, rd_valid, uc, hit, uc_done, fill, last, clear, valid;
   assign off = bus.cpu_addr[IB-1:2];
   assign idx = bus.cpu_addr[IB+INDEX_BITS-1:IB];
   assign tag = bus.cpu_addr[ADDR_W-1:IB+INDEX_BITS];
   assign uc = bus.cpu_addr[ADDR_W-1:ADDR_W-16] == UC_HI;
   assign nxt = ctr + 1'b1;
   assign hit = reset && state == IDLE && bus.cpu_req && !uc && rd_valid && rd_tag == tag;
   assign uc_done = reset && state == UNCACHED && bus.mem_rvalid;
   assign fill = reset && state == REFILL && bus.mem_rvalid;
   assign last = fill && &ctr;
   // a flush seen at any point of a refill, including its last word, leaves that line invalid
   assign clear = (bus.flush && state != REFILL) || (last && (flush_pend || bus.flush));
   assign valid = hit || uc_done;
   assign bus.cpu_valid = valid;
   assign bus.cpu_inst = hit ? rd_data : uc_done ? bus.mem_rdata : '0;
   assign bus.cpu_stall = reset && bus.cpu_req && !valid;
   assign bus.mem_req = reset && req_q;
   assign bus.mem_addr = reset ? addr_q : '0;
   icache_line_store store (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .rd_idx(idx),
      .rd_off(off),
      .rd_valid(rd_valid),
      .rd_tag(rd_tag),
      .rd_data(rd_data),
      .wr_en(fill),
      .wr_idx(base_idx),
      .wr_off(ctr),
      .wr_data(bus.mem_rdata),
      .set_en(last && !flush_pend && !bus.flush),
      .set_tag(base_tag)
   );
   always_ff @(posedge clk)
      if (!reset) begin
         state <= IDLE;
         ctr <= '0;
         flush_pend <= 1'b0;
         req_q <= 1'b0;
         addr_q <= '0;
         base_idx <= '0;
         base_tag <= '0;
      end else
         case (state)
            IDLE: if (bus.cpu_req && !hit) begin
               state <= uc ? UNCACHED : REFILL;
               req_q <= 1'b1;
               addr_q <= uc ? bus.cpu_addr : {tag, idx, {WO{1'b0}}, 2'b00};
               base_idx <= idx;
               base_tag <= tag;
            end
            REFILL: begin
               flush_pend <= !last && (flush_pend || bus.flush);
               if (fill) begin
                  ctr <= nxt;
                  addr_q <= {base_tag, base_idx, nxt, 2'b00};
                  state <= last ? IDLE : REFILL;
                  req_q <= !last;
               end
            end
            default: if (bus.mem_rvalid) begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
endmodule

// File: tb/tb_icache_line_refill.sv
// tb_icache_line_refill: directed and random fetches checked against a line-presence model
module tb_icache_line_refill;
   import icache_pkg::*;
   logic clk = 0;
   logic reset = 0;
   icache_line_refill_if bus ();
   icache_line_refill dut (.clk(clk), .reset(reset), .bus(bus));
   int n_asrt = 0;
   int n_fail = 0;
   int ws = 0;
   int wcnt = 0;
   bit resp_en = 1;
   bit force_rv = 0;
   logic [31:0] got [$];
   bit mv [16];
   logic [23:0] mt [16];
   always #5 clk = ~clk;
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a[31:4] == 28'h4) return 32'hA0 + 32'(a[3:2]);
      if (a == 32'h1c09_0010) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5a5a, a[31:16]};
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // memory: answers each request after ws idle cycles, logging the addresses it served
   initial begin
      bus.mem_rvalid = 0;
      bus.mem_rdata = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!resp_en) bus.mem_rvalid = force_rv;
         else if (bus.mem_req && wcnt == ws) begin
            bus.mem_rvalid = 1;
            bus.mem_rdata = memf(bus.mem_addr);
            got.push_back(bus.mem_addr);
            wcnt = 0;
         end else begin
            bus.mem_rvalid = 0;
            bus.mem_rdata = 32'hBAD0_BAD0;
            wcnt = bus.mem_req ? wcnt + 1 : 0;
         end
      end
   end
   task automatic invalidate_model();
      for (int j = 0; j < 16; j++) mv[j] = 0;
   endtask
   task automatic fetch(input logic [31:0] a, input int w, input int fl_in);
      logic [31:0] exp_q [$];
      logic [3:0] idx;
      logic [23:0] tg;
      bit uc, hit;
      int r, edges, k, fl, reps;
      logic stall0;
      idx = a[7:4];
      tg = a[31:8];
      uc = a[31:16] == 16'h1c09;
      hit = !uc && mv[idx] && mt[idx] == tg;
      r = WORDS_PER_LINE * (w + 1);
      fl = fl_in > (uc ? 1 + w : hit ? 0 : r) ? -1 : fl_in;
      reps = fl >= 1 ? 2 : 1;
      edges = uc ? 1 + w : hit ? 0 : reps * (r + 1);
      if (uc) exp_q.push_back(a);
      else if (!hit)
         for (int n = 0; n < reps; n++)
            for (int j = 0; j < WORDS_PER_LINE; j++) exp_q.push_back({a[31:4], 2'(j), 2'b00});
      @(posedge clk);
      #1;
      ws = w;
      got.delete();
      bus.cpu_req = 1;
      bus.cpu_addr = a;
      bus.flush = fl == 0;
      k = 0;
      @(negedge clk);
      stall0 = bus.cpu_stall;
      while (!bus.cpu_valid && k <= edges + 20) begin
         @(posedge clk);
         #1;
         k++;
         bus.flush = fl == k;
         @(negedge clk);
      end
      check("latency", k, edges);
      check("inst", bus.cpu_inst, memf(a));
      check("stall", stall0, edges > 0);
      if (hit) check("hit_mem_req", bus.mem_req, 0);
      bus.cpu_req = 0;
      @(posedge clk);
      #1;
      bus.flush = 0;
      check("words", got.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got.size(); j++) check("mem_addr", got[j], exp_q[j]);
      if (fl >= 0) invalidate_model();
      if (!uc && !hit) begin
         mv[idx] = 1;
         mt[idx] = tg;
      end
   endtask
   initial begin
      bus.cpu_req = 1;
      bus.cpu_addr = 32'h1c09_0000;
      bus.flush = 0;
      @(negedge clk);
      check("rst_valid", bus.cpu_valid, 0);
      check("rst_stall", bus.cpu_stall, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_inst", bus.cpu_inst, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      @(posedge clk);
      #1;
      reset = 1;
      bus.cpu_req = 0;
      @(negedge clk);
      check("idle_valid", bus.cpu_valid, 0);
      check("idle_stall", bus.cpu_stall, 0);
      check("idle_mem_req", bus.mem_req, 0);
      fetch(32'h40, 0, -1);
      fetch(32'h44, 0, -1);
      fetch(32'h48, 0, -1);
      fetch(32'h4C, 0, -1);
      fetch(32'h1c09_0010, 3, -1);
      fetch(32'h1c09_0010, 3, -1);
      @(posedge clk);
      #1;
      bus.flush = 1;
      @(negedge clk);
      check("flush_idle_valid", bus.cpu_valid, 0);
      check("flush_idle_mem_req", bus.mem_req, 0);
      @(posedge clk);
      #1;
      bus.flush = 0;
      invalidate_model();
      fetch(32'h40, 0, -1);
      fetch(32'h440, 0, -1);
      fetch(32'h40, 0, -1);
      fetch(32'h80, 0, 2);
      fetch(32'h40, 0, -1);
      fetch(32'h84, 0, 0);
      fetch(32'h88, 1, -1);
      @(posedge clk);
      #1;
      ws = 0;
      bus.cpu_req = 1;
      bus.cpu_addr = 32'hC0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 0;
      resp_en = 0;
      force_rv = 1;
      @(negedge clk);
      check("rst_mid_mem_req", bus.mem_req, 0);
      check("rst_mid_stall", bus.cpu_stall, 0);
      @(posedge clk);
      #1;
      reset = 1;
      bus.cpu_req = 0;
      @(negedge clk);
      check("late_rv_mem_req", bus.mem_req, 0);
      check("late_rv_valid", bus.cpu_valid, 0);
      check("late_rv_mem_addr", bus.mem_addr, 0);
      @(posedge clk);
      #1;
      force_rv = 0;
      resp_en = 1;
      invalidate_model();
      fetch(32'hC0, 0, -1);
      fetch(32'h40, 0, -1);
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         int fl;
         a = $urandom_range(0, 4) == 0 ? {16'h1c09, 14'($urandom), 2'b00}
                                        : {24'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom), 2'b00};
         fl = -1;
         if ($urandom_range(0, 5) == 0) fl = int'($urandom_range(0, 12));
         fetch(a, int'($urandom_range(0, 2)), fl);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
